// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM PIO command register between NUM_REQ requesters.
// Optional read-back check of every write is compiled in with `define PIO_VERIFY_EN.
module pio_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [ADDR_W-1:0]         avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write_n,
    output logic [DATA_W-1:0]         avm_writedata,
    input  logic [DATA_W-1:0]         avm_readdata,
    output logic                      verify_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_s;
    logic [IDX_W-1:0]     winner_r, winner_nx_s, winner_s;
    logic                 found_s;
    logic [IDX_W:0]       cand_s;
    logic [DATA_W-1:0]    win_data_s;
    logic [DATA_W-1:0]    wdata_r, wdata_s;
    logic [NUM_REQ-1:0]   grant_r, grant_s;
    logic                 busy_r, busy_s;
    logic                 cs_r, cs_s;
    logic                 write_n_r, write_n_s;
    logic [ADDR_W-1:0]    addr_r;
    logic                 verr_r, verr_s;

    // Any bit difference between the read-back and the written word.
    function automatic logic word_mismatch(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        word_mismatch = |(a ^ b);
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Winner search: first set request at or above rr_ptr, wrapping; index never leaves 0..NUM_REQ-1.
    always_comb begin
        winner_s   = '0;
        found_s    = 1'b0;
        cand_s     = '0;
        win_data_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
            if (cand_s >= NUM_REQ_W) begin
                cand_s = cand_s - NUM_REQ_W;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[IDX_W-1:0]]) begin
                found_s  = 1'b1;
                winner_s = cand_s[IDX_W-1:0];
            end else begin
                winner_s = winner_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_s == IDX_W'(i)) begin
                win_data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Next state and next registered output values.
    always_comb begin
        state_s     = state_r;
        rr_ptr_s    = rr_ptr_r;
        winner_nx_s = winner_r;
        wdata_s     = wdata_r;
        grant_s     = '0;
        cs_s        = 1'b0;
        write_n_s   = 1'b1;
        verr_s      = verr_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s     = ST_WRITE;
                    winner_nx_s = winner_s;
                    wdata_s     = win_data_s;
                    cs_s        = 1'b1;
                    write_n_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
`ifdef PIO_VERIFY_EN
                state_s = ST_READ;
                cs_s    = 1'b1;
`else
                state_s = ST_DONE;
                grant_s = onehot(winner_r);
`endif
            end
            ST_READ: begin
`ifdef PIO_VERIFY_EN
                state_s = ST_DONE;
                grant_s = onehot(winner_r);
                if (word_mismatch(avm_readdata, wdata_r)) begin
                    verr_s = 1'b1;
                end else begin
                    verr_s = verr_r;
                end
`else
                state_s = ST_IDLE;
`endif
            end
            ST_DONE: begin
                state_s  = ST_IDLE;
                rr_ptr_s = (winner_r == LAST_IDX) ? IDX_W'(0) : winner_r + IDX_W'(1);
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
`ifndef PIO_VERIFY_EN
        verr_s = 1'b0;
`endif
        busy_s = (state_s != ST_IDLE);
    end

    // State, arbitration and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= '0;
            winner_r  <= '0;
            wdata_r   <= '0;
            grant_r   <= '0;
            busy_r    <= 1'b0;
            cs_r      <= 1'b0;
            write_n_r <= 1'b1;
            addr_r    <= '0;
            verr_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            rr_ptr_r  <= rr_ptr_s;
            winner_r  <= winner_nx_s;
            wdata_r   <= wdata_s;
            grant_r   <= grant_s;
            busy_r    <= busy_s;
            cs_r      <= cs_s;
            write_n_r <= write_n_s;
            addr_r    <= '0;
            verr_r    <= verr_s;
        end
    end

`ifndef PIO_VERIFY_EN
    logic unused_readdata_s;
    assign unused_readdata_s = ^avm_readdata;
`endif

    assign grant          = grant_r;
    assign busy           = busy_r;
    assign avm_address    = addr_r;
    assign avm_chipselect = cs_r;
    assign avm_write_n    = write_n_r;
    assign avm_writedata  = wdata_r;
    assign verify_err     = verr_r;

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Randomized and directed bench for pio_write_arbiter against a transaction-level round-robin model.
module tb_pio_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
`ifdef PIO_VERIFY_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    grant;
    logic            busy;
    logic [1:0]      avm_address;
    logic            avm_chipselect;
    logic            avm_write_n;
    logic [DW-1:0]   avm_writedata;
    logic [DW-1:0]   avm_readdata;
    logic            verify_err;

    pio_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .grant(grant), .busy(busy), .avm_address(avm_address),
        .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    // model state
    bit          chk_en = 1'b0;
    bit          force_bad = 1'b0;
    int          ptr, free_at, strobe_at, grant_at;
    logic [N-1:0] exp_gnt;
    logic [DW-1:0] exp_data;
    logic [N-1:0] g_seen;
    int          gq[$];
    int          gc[$];
    logic [DW-1:0] pio_reg = '0;
    logic [N-1:0] dropped_prev = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // simple PIO register model for read-back
    always @(posedge clk) if (avm_chipselect && !avm_write_n) pio_reg <= avm_writedata;
    assign avm_readdata = force_bad ? 32'hDEADBEEF : pio_reg;

    always @(negedge clk) begin
        if (!chk_en) begin
            ptr = 0; free_at = 0; strobe_at = -10; grant_at = -10; g_seen = '0;
        end else begin
            chk("grant", 32'(grant), (cyc == grant_at) ? 32'(exp_gnt) : 32'd0);
            chk("cs", 32'(avm_chipselect), 32'(cyc >= strobe_at && cyc < grant_at));
            chk("write_n", 32'(avm_write_n), 32'(cyc != strobe_at));
            chk("busy", 32'(busy), 32'(cyc >= strobe_at && cyc <= grant_at));
            if (avm_chipselect) chk("addr", 32'(avm_address), 32'd0);
            if (cyc == strobe_at) chk("wdata", avm_writedata, exp_data);
            if (!force_bad) chk("verr", 32'(verify_err), 32'd0);
            g_seen = grant;
            if (grant != '0) begin
                for (int i = 0; i < N; i++) if (grant[i]) begin gq.push_back(i); gc.push_back(cyc); end
            end
            if (cyc >= free_at && req != '0) begin
                int w;
                w = pick(req, ptr);
                exp_data  = req_data[w*DW +: DW];
                exp_gnt   = N'(1) << w;
                strobe_at = cyc + 1;
                grant_at  = cyc + LAT;
                free_at   = grant_at + 1;
                ptr       = (w + 1) % N;
            end
        end
    end

    task automatic step();
        logic [N-1:0] nd;
        @(posedge clk); #1;
        nd = g_seen & req;
        req = req & ~g_seen;
        dropped_prev = nd;
    endtask

    task automatic raise(input int i, input logic [DW-1:0] d);
        req_data[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    // mode 0: drops only, 1: re-arm requesters 0 and 2, 2: random requests
    task automatic drive(input int mode, input int budget, input int want);
        int n;
        n = 0;
        while (n < budget && (want < 0 || gq.size() < want)) begin
            logic [N-1:0] dp;
            dp = dropped_prev;
            step();
            if (mode == 1) begin
                for (int i = 0; i < N; i += 2) if (dp[i]) raise(i, $urandom);
            end else if (mode == 2) begin
                for (int i = 0; i < N; i++)
                    if (!req[i] && !dropped_prev[i] && ($urandom_range(3) == 0)) raise(i, $urandom);
            end
            @(negedge clk); #1;
            n++;
        end
        if (want >= 0) chk("timeout", 32'(gq.size() >= want), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; chk_en = 1'b0; req = '0; dropped_prev = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1; chk_en = 1'b1;
    endtask

    initial begin
        int base, t0;
        logic hit;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_wn", 32'(avm_write_n), 32'd1);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_verr", 32'(verify_err), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1; chk_en = 1'b1;

        // single request
        step();
        raise(0, 32'h12345678);
        t0 = cyc; base = gq.size();
        @(negedge clk); #1;
        drive(0, 20, base + 1);
        chk("single_idx", 32'(gq[base]), 32'd0);
        chk("single_lat", 32'(gc[base] - t0), 32'(LAT));
        step(); @(negedge clk); #1;
        chk("single_busy_low", 32'(busy), 32'd0);

        // all requesters together, from a fresh pointer
        do_reset();
        for (int i = 0; i < N; i++) raise(i, 32'hA0 + 32'(i));
        base = gq.size();
        @(negedge clk); #1;
        drive(0, 40, base + 4);
        for (int k = 0; k < 4; k++) begin
            chk("all_order", 32'(gq[base+k]), 32'(k));
            if (k > 0) chk("all_spacing", 32'(gc[base+k] - gc[base+k-1]), 32'(LAT + 1));
        end

        // fairness between 0 and 2
        step();
        raise(0, $urandom); raise(2, $urandom);
        base = gq.size();
        @(negedge clk); #1;
        drive(1, 80, base + 8);
        for (int k = base + 1; k < base + 8; k++) begin
            chk("fair_alt", 32'(gq[k] != gq[k-1]), 32'd1);
            chk("fair_set", 32'(gq[k] == 0 || gq[k] == 2), 32'd1);
        end
        drive(0, 10, -1);

        // random traffic
        drive(2, 900, -1);
        req = '0;

        // reset during a write
        do_reset();
        raise(2, 32'h0BADF00D);
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write_n) hit = 1'b1;
        end
        chk("midrst_strobe_seen", 32'(hit), 32'd1);
        #2 reset_n = 1'b0; chk_en = 1'b0;
        #1;
        chk("midrst_cs", 32'(avm_chipselect), 32'd0);
        chk("midrst_wn", 32'(avm_write_n), 32'd1);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b1; chk_en = 1'b1;
        base = gq.size();
        @(negedge clk); #1;
        drive(0, 20, base + 1);
        chk("midrst_served", 32'(gq[base]), 32'd2);
        drive(0, 5, -1);

`ifdef PIO_VERIFY_EN
        do_reset();
        force_bad = 1'b1;
        raise(0, 32'h61900000);
        base = gq.size();
        @(negedge clk); #1;
        drive(0, 20, base + 1);
        chk("verify_err_at_grant", 32'(verify_err), 32'd1);
        chk("verify_grant", 32'(gq[base]), 32'd0);
        drive(0, 11, -1);
        chk("verify_err_sticky", 32'(verify_err), 32'd1);
        do_reset();
        force_bad = 1'b0;
        chk("verify_err_cleared", 32'(verify_err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pio_write_arbiter.md
# pio_write_arbiter

Round-robin arbiter that shares one 32-bit Avalon-MM PIO output register (the robot command word, slave address 0) between several on-chip requesters. Each requester presents a command word and a request. The block grants one requester at a time, drives a single-cycle Avalon write to the PIO slave and returns a one-cycle grant when the write has completed. It sits between the game/control logic and the command PIO in the Qsys system.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, command word width; must match the PIO width
- ADDR_W, 2, PIO slave address width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  request per requester; level, held until grant
- req_data  in  NUM_REQ*DATA_W  packed command words; requester i at [i*DATA_W +: DATA_W]
- grant  out  NUM_REQ  one-hot, one-cycle pulse: requester's write completed
- busy  out  1  high whenever state != IDLE
- avm_address  out  ADDR_W  always 0 when chipselect is high
- avm_chipselect  out  1  PIO chip select
- avm_write_n  out  1  active-low write strobe
- avm_writedata  out  DATA_W  latched winner word
- avm_readdata  in  DATA_W  PIO read-back (used only with verify)
- verify_err  out  1  sticky mismatch flag (verify builds only)

## Operation
- FSM states: IDLE, WRITE, READ (verify builds only), DONE.
- IDLE: if any req bit is set, choose the winner. The winner is the first set bit at or above rr_ptr, searching upward with wrap. Latch the winner index and its req_data, then go to WRITE. If no req bit is set, stay in IDLE.
- WRITE: chipselect=1, write_n=0, address=0, writedata=latched word, for exactly one cycle. Next state is READ if verify is compiled in, otherwise DONE.
- READ: chipselect=1, write_n=1, address=0. Compare avm_readdata with the latched word in this cycle. Go to DONE.
- DONE: grant[winner]=1 for one cycle. Set rr_ptr = (winner+1) mod NUM_REQ. Return to IDLE.
- The requester must hold req and req_data stable until it sees grant, and drop req in the cycle after grant. If req is still high in the IDLE cycle that follows DONE, it counts as a new request.
- Changes to req_data after latching have no effect on the write in progress.
- req bits at or above NUM_REQ do not exist; no out-of-range index is ever selected.

## Timing
- Reset values: grant=0, busy=0, chipselect=0, write_n=1, address=0, writedata=0, verify_err=0, rr_ptr=0, state=IDLE.
- All outputs are registered. Winner selection is combinational from req and rr_ptr in IDLE.
- Latency without verify: req sampled at cycle T, write strobe at T+1, grant at T+2. A new write can start at T+3, giving a maximum throughput of one write per 3 cycles.
- Latency with verify: write strobe at T+1, read at T+2, grant at T+3.
- Simultaneous requests are resolved purely by rr_ptr. After reset, requester 0 has top priority.
- Reset asserted mid-operation: outputs return to their reset values immediately (asynchronously). Any pending grant is lost. A write already strobed at a clock edge stays in the PIO. rr_ptr returns to 0.

## Configuration
- PIO_VERIFY_EN defined: READ state is compiled in. After every write, the block reads back address 0. On any bit mismatch, verify_err is set to 1 and held until reset. grant is still issued on a mismatch.
- PIO_VERIFY_EN undefined: no READ state. verify_err is tied to 0 and avm_readdata is ignored. Latency is as given for the non-verify case.

## Test plan
- Single request: after reset, req=4'b0001, req_data[31:0]=0x12345678 at T. Expect at T+1 chipselect=1, write_n=0, address=0, writedata=0x12345678. Expect at T+2 grant=4'b0001, and busy low at T+3.
- All requesters at once: req=4'b1111 held, with data 0xA0..0xA3, each requester dropping req after its grant. Expect grants in order 0,1,2,3, 3 cycles apart, with the matching writedata on each write.
- Fairness: req0 and req2 re-raised immediately after each grant. Expect grants alternating 0,2,0,2; requester 0 is never granted twice in a row.
- Verify (PIO_VERIFY_EN): write 0x61900000 while the bench forces avm_readdata=0xDEADBEEF. Expect verify_err=1 at T+3 with grant still pulsed, verify_err still 1 after 10 idle cycles, and 0 only after reset.
- Reset mid-write: pull reset_n low during WRITE. Expect chipselect=0, write_n=1, grant=0 immediately. After release with req=4'b0100 held, requester 2 is served and grant is pulsed normally.
